// File: rtl/tone_pkg.sv
// Shared definitions for the tone sequencer: FSM state encoding, note
// half-periods for a 100 MHz clock, durations for a 1 kHz tick, and stock tunes.
package tone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } tone_state_e;

  localparam int TUNE_NOTES = 8;
  localparam int TUNE_DIV_W = 20;
  localparam int TUNE_DUR_W = 12;

  // Half-period in clocks = 100e6 / (2 * f_note), rounded
  localparam logic [19:0] REST    = 20'd0;
  localparam logic [19:0] NOTE_C4 = 20'd191113;
  localparam logic [19:0] NOTE_D4 = 20'd170262;
  localparam logic [19:0] NOTE_E4 = 20'd151686;
  localparam logic [19:0] NOTE_F4 = 20'd143173;
  localparam logic [19:0] NOTE_G4 = 20'd127551;
  localparam logic [19:0] NOTE_A4 = 20'd113636;
  localparam logic [19:0] NOTE_B4 = 20'd101239;
  localparam logic [19:0] NOTE_C5 = 20'd95557;
  localparam logic [19:0] NOTE_D5 = 20'd85131;
  localparam logic [19:0] NOTE_E5 = 20'd75843;
  localparam logic [19:0] NOTE_F5 = 20'd71586;
  localparam logic [19:0] NOTE_G5 = 20'd63776;
  localparam logic [19:0] NOTE_A5 = 20'd56818;
  localparam logic [19:0] NOTE_B5 = 20'd50619;
  localparam logic [19:0] NOTE_C6 = 20'd47778;

  localparam logic [11:0] DUR_8TH   = 12'd125;
  localparam logic [11:0] DUR_QTR   = 12'd250;
  localparam logic [11:0] DUR_HALF  = 12'd500;
  localparam logic [11:0] DUR_WHOLE = 12'd1000;

  // Note 0 sits in the least significant slot, so each list reads last-to-first
  localparam logic [TUNE_NOTES*TUNE_DIV_W-1:0] WIN_TUNE_DIV =
    {NOTE_C6, REST, NOTE_G5, NOTE_E5, NOTE_C5, NOTE_G4, NOTE_E4, NOTE_C4};
  localparam logic [TUNE_NOTES*TUNE_DUR_W-1:0] WIN_TUNE_DUR =
    {DUR_WHOLE, DUR_8TH, DUR_8TH, DUR_8TH, DUR_8TH, DUR_8TH, DUR_8TH, DUR_8TH};

  localparam logic [TUNE_NOTES*TUNE_DIV_W-1:0] LOSE_TUNE_DIV =
    {NOTE_C4, NOTE_D4, NOTE_E4, REST, NOTE_F4, NOTE_G4, NOTE_A4, NOTE_B4};
  localparam logic [TUNE_NOTES*TUNE_DUR_W-1:0] LOSE_TUNE_DUR =
    {DUR_WHOLE, DUR_QTR, DUR_QTR, DUR_8TH, DUR_QTR, DUR_QTR, DUR_QTR, DUR_QTR};

  localparam logic [TUNE_NOTES*TUNE_DIV_W-1:0] START_TUNE_DIV =
    {NOTE_C6, NOTE_B5, NOTE_A5, NOTE_F5, NOTE_D5, REST, NOTE_C5, NOTE_C5};
  localparam logic [TUNE_NOTES*TUNE_DUR_W-1:0] START_TUNE_DUR =
    {DUR_HALF, DUR_8TH, DUR_8TH, DUR_8TH, DUR_8TH, DUR_8TH, DUR_8TH, DUR_8TH};

endpackage

// File: rtl/square_gen.sv
// Half-period counter and square-wave phase. Exposes the next phase so the
// caller can register audio on the same edge the phase changes.
module square_gen
  import tone_pkg::*;
#(
  parameter int DIV_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             phase_next
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  // Divider, counter and phase registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= {DIV_W{1'b0}};
      cnt_q   <= {DIV_W{1'b0}};
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Load restarts a note low; a zero divider is a rest and holds phase at 0
  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (load) begin
      div_d   = div;
      cnt_d   = (div == {DIV_W{1'b0}}) ? {DIV_W{1'b0}} : div - DIV_W'(1);
      phase_d = 1'b0;
    end else if (en) begin
      if (div_q == {DIV_W{1'b0}}) begin
        cnt_d   = {DIV_W{1'b0}};
        phase_d = 1'b0;
      end else if (cnt_q == {DIV_W{1'b0}}) begin
        cnt_d   = div_q - DIV_W'(1);
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q - DIV_W'(1);
      end
    end else begin
      phase_d = phase_q;
    end
  end

  assign phase_next = phase_d;

endmodule

// File: rtl/tone_sequencer.sv
// Melody player: steps through NOTES (divider, duration) pairs and drives a
// square wave, with loop, stop and mute control.
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int NOTES   = 8,
  parameter int DIV_W   = 20,
  parameter int DUR_W   = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop,
  input  logic                     mute,
  input  logic [NOTES*DIV_W-1:0]   song_div,
  input  logic [NOTES*DUR_W-1:0]   song_dur,
  output logic                     audio,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NOTES)-1:0] note_idx
);

  localparam int TDIV  = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
  localparam int IDX_W = $clog2(NOTES);
  localparam int PRE_W = (TDIV > 1) ? $clog2(TDIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TDIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NOTES - 1);

  tone_state_e      state_q, state_d;
  logic [IDX_W-1:0] note_idx_q, note_idx_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             audio_q, audio_d;
  logic             sq_load, sq_en, phase_next;
  logic [DIV_W-1:0] cur_div;
  logic [DUR_W-1:0] cur_dur;
  logic             pre_wrap, note_end;

  assign cur_div  = song_div[int'(note_idx_q) * DIV_W +: DIV_W];
  assign cur_dur  = song_dur[int'(note_idx_q) * DUR_W +: DUR_W];
  assign pre_wrap = (pre_q == PRE_MAX);
  // A zero duration ends after its single PLAY cycle
  assign note_end = (rem_q == {DUR_W{1'b0}}) || (pre_wrap && rem_q == DUR_W'(1));

  square_gen #(.DIV_W(DIV_W)) u_square_gen (
    .clk        (clk),
    .rst        (rst),
    .load       (sq_load),
    .en         (sq_en),
    .div        (cur_div),
    .phase_next (phase_next)
  );

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      note_idx_q <= {IDX_W{1'b0}};
      pre_q      <= {PRE_W{1'b0}};
      rem_q      <= {DUR_W{1'b0}};
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      audio_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_idx_q <= note_idx_d;
      pre_q      <= pre_d;
      rem_q      <= rem_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      audio_q    <= audio_d;
    end
  end

  // Next-state, sequencing and output logic
  always_comb begin
    state_d    = state_q;
    note_idx_d = note_idx_q;
    pre_d      = pre_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    sq_load    = 1'b0;
    sq_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d    = ST_LOAD;
          note_idx_d = {IDX_W{1'b0}};
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (stop) begin
          state_d    = ST_IDLE;
          note_idx_d = {IDX_W{1'b0}};
        end else begin
          state_d    = ST_PLAY;
          sq_load    = 1'b1;
          pre_d      = {PRE_W{1'b0}};
          rem_d      = cur_dur;
        end
      end
      ST_PLAY: begin
        if (stop) begin
          state_d    = ST_IDLE;
          note_idx_d = {IDX_W{1'b0}};
          pre_d      = {PRE_W{1'b0}};
          rem_d      = {DUR_W{1'b0}};
        end else begin
          sq_en = 1'b1;
          if (note_end) begin
            pre_d = {PRE_W{1'b0}};
            if (note_idx_q != IDX_LAST) begin
              note_idx_d = note_idx_q + IDX_W'(1);
              state_d    = ST_LOAD;
            end else if (loop) begin
              note_idx_d = {IDX_W{1'b0}};
              state_d    = ST_LOAD;
            end else begin
              state_d    = ST_IDLE;
              done_d     = 1'b1;
            end
          end else if (pre_wrap) begin
            pre_d = {PRE_W{1'b0}};
            rem_d = rem_q - DUR_W'(1);
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        note_idx_d = {IDX_W{1'b0}};
      end
    endcase
    busy_d  = (state_d != ST_IDLE);
    audio_d = (state_d == ST_PLAY) && phase_next && !mute;
  end

  assign audio    = audio_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = note_idx_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: directed checkpoint table, multi-cycle corner
// sequences, and randomized traffic against a note-level reference model.
module tb_tone_sequencer;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int TDIV    = CLK_HZ / TICK_HZ;
  localparam int NOTES   = 4;
  localparam int DIV_W   = 4;
  localparam int DUR_W   = 4;

  logic                   clk = 1'b0;
  logic                   rst, start, stop, loop, mute;
  logic [NOTES*DIV_W-1:0] song_div;
  logic [NOTES*DUR_W-1:0] song_dur;
  logic                   audio, busy, done;
  logic [1:0]             note_idx;

  int errors = 0;
  int checks = 0;
  int c, busy_cnt, done_cnt;

  tone_sequencer #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NOTES(NOTES), .DIV_W(DIV_W), .DUR_W(DUR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop), .mute(mute),
    .song_div(song_div), .song_dur(song_dur),
    .audio(audio), .busy(busy), .done(done), .note_idx(note_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    bit busy;
    int idx;
    bit audio;
    bit done;
  } vec_t;
  vec_t tbl[$];

  // Reference model state: note-level view (play-cycle count k within a note)
  int m_busy, m_load, m_idx, m_k, m_div, m_dur, m_done, m_audio;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at c=%0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic tally();
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic run_to(input int target);
    while (c < target) begin
      step();
      c++;
      tally();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    c = 1;
    busy_cnt = 0;
    done_cnt = 0;
    tally();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; mute = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic model_reset();
    m_busy = 0; m_load = 0; m_idx = 0; m_k = 0; m_div = 0; m_dur = 0;
    m_done = 0; m_audio = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs now driven
  task automatic model_step();
    int len;
    m_done = 0;
    if (!m_busy) begin
      if (start && !stop) begin
        m_busy = 1; m_load = 1; m_idx = 0;
      end
    end else if (stop) begin
      m_busy = 0; m_load = 0; m_idx = 0;
    end else if (m_load) begin
      m_div  = int'(song_div[m_idx*DIV_W +: DIV_W]);
      m_dur  = int'(song_dur[m_idx*DUR_W +: DUR_W]);
      m_load = 0;
      m_k    = 1;
    end else begin
      len = (m_dur == 0) ? 1 : m_dur * TDIV;
      if (m_k >= len) begin
        if (m_idx < NOTES - 1) begin
          m_idx++; m_load = 1;
        end else if (loop) begin
          m_idx = 0; m_load = 1;
        end else begin
          m_busy = 0; m_done = 1;
        end
      end else begin
        m_k++;
      end
    end
    m_audio = (m_busy && !m_load && m_div != 0 && !mute && (((m_k - 1) / m_div) % 2 == 1)) ? 1 : 0;
  endtask

  task automatic play_table(input bit m);
    do_reset();
    mute = m;
    pulse_start();
    foreach (tbl[i]) begin
      run_to(tbl[i].c);
      chk("tbl_busy",  busy,     tbl[i].busy);
      chk("tbl_idx",   note_idx, tbl[i].idx);
      chk("tbl_audio", audio,    m ? 0 : tbl[i].audio);
      chk("tbl_done",  done,     tbl[i].done);
    end
    chk("busy_cycles", busy_cnt, 65);
    chk("done_pulses", done_cnt, 1);
  endtask

  initial begin
    // div={2,0,3,1}, dur={2,1,0,3}; note 0 in the low slot
    song_div = {4'd1, 4'd3, 4'd0, 4'd2};
    song_dur = {4'd3, 4'd0, 4'd1, 4'd2};
    // c = edges since the edge that sampled start; LOAD at 1,22,33,35
    tbl.push_back('{1,  1, 0, 0, 0});
    tbl.push_back('{2,  1, 0, 0, 0});
    tbl.push_back('{3,  1, 0, 0, 0});
    tbl.push_back('{4,  1, 0, 1, 0});
    tbl.push_back('{6,  1, 0, 0, 0});
    tbl.push_back('{21, 1, 0, 1, 0});
    tbl.push_back('{22, 1, 1, 0, 0});
    tbl.push_back('{27, 1, 1, 0, 0});
    tbl.push_back('{33, 1, 2, 0, 0});
    tbl.push_back('{34, 1, 2, 0, 0});
    tbl.push_back('{35, 1, 3, 0, 0});
    tbl.push_back('{36, 1, 3, 0, 0});
    tbl.push_back('{37, 1, 3, 1, 0});
    tbl.push_back('{38, 1, 3, 0, 0});
    tbl.push_back('{65, 1, 3, 1, 0});
    tbl.push_back('{66, 0, 3, 0, 1});
    tbl.push_back('{67, 0, 3, 0, 0});

    // Reset values
    rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; mute = 1'b0;
    c = 0;
    step();
    chk("rst_audio", audio, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_idx",   note_idx, 0);

    play_table(1'b0);
    play_table(1'b1);

    // Looping: wraps to note 0 without done, then ends once loop drops
    do_reset();
    loop = 1'b1;
    pulse_start();
    run_to(66);
    chk("loop_busy", busy, 1);
    chk("loop_idx",  note_idx, 0);
    chk("loop_done", done_cnt, 0);
    loop = 1'b0;
    run_to(131);
    chk("loop_end_done", done, 1);
    chk("loop_end_busy", busy, 0);
    chk("loop_done_cnt", done_cnt, 1);

    // Stop mid note 0 while audio is high
    do_reset();
    pulse_start();
    run_to(5);
    chk("pre_stop_audio", audio, 1);
    stop = 1'b1;
    run_to(6);
    stop = 1'b0;
    chk("stop_busy",  busy, 0);
    chk("stop_audio", audio, 0);
    chk("stop_idx",   note_idx, 0);
    run_to(30);
    chk("stop_no_done", done_cnt, 0);
    chk("stop_idle",    busy, 0);

    // start and stop together in IDLE
    do_reset();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);
    step(); step();
    chk("ss_busy_later", busy, 0);

    // start during PLAY is ignored
    do_reset();
    pulse_start();
    run_to(10);
    start = 1'b1;
    run_to(11);
    start = 1'b0;
    run_to(22);
    chk("restart_idx1", note_idx, 1);
    run_to(33);
    chk("restart_idx2", note_idx, 2);
    run_to(66);
    chk("restart_done", done, 1);

    // Asynchronous reset mid note 3
    do_reset();
    pulse_start();
    run_to(51);
    chk("pre_rst_audio", audio, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_audio", audio, 0);
    chk("arst_busy",  busy, 0);
    chk("arst_idx",   note_idx, 0);
    chk("arst_done",  done, 0);
    step();
    rst = 1'b0;
    step();
    pulse_start();
    chk("replay_busy", busy, 1);
    chk("replay_idx",  note_idx, 0);
    run_to(4);
    chk("replay_audio", audio, 1);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    c = 0;
    for (int n = 0; n < 4000; n++) begin
      chk("rnd_busy",  busy,     m_busy);
      chk("rnd_idx",   note_idx, m_idx);
      chk("rnd_audio", audio,    m_audio);
      chk("rnd_done",  done,     m_done);
      start = ($urandom_range(0, 49) == 0);
      stop  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) == 0) loop = ~loop;
      if ($urandom_range(0, 99) == 0) mute = ~mute;
      if ($urandom_range(0, 149) == 0) begin
        song_div = 16'($urandom);
        song_dur = 16'($urandom);
      end
      model_step();
      step();
      c++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
# tone_sequencer

Parametrised melody player for the game's audio path: it plays a tune of NOTES (divider, duration) pairs as a 1-bit square wave for the speaker pin. Each note has its own pitch or is a rest. Tunes can play once or loop, and can be stopped at any time. One instance, driven by different song constants, replaces the per-tune fixed-pitch generators (win, lose, start jingles).

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- TICK_HZ, 1000, duration tick rate; TDIV = CLK_HZ/TICK_HZ clocks per tick (integer, ≥1)
- NOTES, 8, notes per tune (≥2)
- DIV_W, 20, width of half-period divider per note
- DUR_W, 12, width of duration per note, in ticks
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to play the tune from note 0
- stop  in  1  one-cycle abort request
- loop  in  1  level, sampled at the end of the last note: 1 = restart at note 0
- mute  in  1  level: forces audio to 0; sequencing continues
- song_div  in  NOTES*DIV_W  half-period in clocks for note i at bits [i*DIV_W +: DIV_W]; 0 = rest
- song_dur  in  NOTES*DUR_W  duration in ticks for note i, same packing
- audio  out  1  square-wave output
- busy  out  1  high in LOAD/PLAY
- done  out  1  one-cycle pulse on natural (non-looped) tune end
- note_idx  out  $clog2(NOTES)  index of the current note

## Operation
- States: IDLE, LOAD, PLAY.
- Reset: state IDLE, audio 0, busy 0, done 0, note_idx 0, all counters 0.
- IDLE: audio 0. start=1 and stop=0 → LOAD with note_idx←0. If start=1 and stop=1 together, stop wins and the block stays IDLE.
- LOAD (1 cycle): latch div/dur of note_idx. Half-period counter ← div−1. Tick prescaler ← 0. Remaining ticks ← dur. Internal square-wave phase ← 0. → PLAY.
- PLAY, pitch (div≠0): each cycle, counter==0 → toggle phase, reload div−1; otherwise decrement.
- PLAY, rest (div==0): phase held 0.
- PLAY, duration: the prescaler counts 0..TDIV−1. On wrap, remaining decrements. The note ends in the cycle the last tick wraps, so a note lasts exactly dur*TDIV PLAY cycles. dur==0 lasts 1 PLAY cycle.
- Note end, note_idx<NOTES−1: note_idx+1, → LOAD.
- Note end, last note, loop=1: note_idx←0, → LOAD.
- Note end, last note, loop=0: → IDLE, done=1 for that one cycle.
- audio = phase & ~mute, registered. Always 0 outside PLAY.
- stop=1 in LOAD/PLAY → IDLE on the next edge. audio←0, note_idx←0, no done pulse.
- start while busy is ignored.
- song_div/song_dur are read only in LOAD. Changing them mid-note takes effect at the next LOAD.
- Arithmetic is unsigned. Counters never underflow: reload happens at 0.

## Timing
- start high at edge t: busy=1 from t+1 (LOAD), PLAY from t+2.
- First audio rise: div cycles after PLAY entry. Period = 2*div clocks. Example: 100 MHz, 440 Hz → div 113636.
- Inter-note gap: each LOAD costs 1 cycle with audio 0, so tune length = Σ(max(dur*TDIV,1)+1) cycles.
- done and the busy fall occur on the same edge. done is never high while busy.
- Reset mid-tune: all outputs return to their reset values immediately (asynchronous).

## Structure
- Shared package tone_pkg holds the note half-period constants for CLK_HZ=100 MHz (NOTE_C4 … NOTE_C6, REST=0), duration constants, and the packed song_div/song_dur constants for the WIN_TUNE, LOSE_TUNE and START_TUNE songs.
- Sub-module square_gen (half-period counter + phase, with load/enable) is instantiated once. The FSM, prescaler, duration counter and index live in tone_sequencer.

## Test plan
All scenarios use CLK_HZ=1000, TICK_HZ=100 (TDIV=10), NOTES=4, div={2,0,3,1}, dur={2,1,0,3}.
- Reset then start, loop=0:
  - busy rises 1 cycle after start.
  - Note0: audio toggles every 2 cycles for 20 PLAY cycles.
  - Note1: 10 cycles at 0.
  - Note2: 1 PLAY cycle.
  - Note3: toggles every cycle for 30 cycles.
  - done pulses once; total busy = 65 cycles.
- loop=1: after note3, note_idx returns to 0 with no done. Dropping loop before the final note ends the tune with done.
- stop asserted mid note0: busy and audio are 0 on the next cycle, no done, note_idx=0.
- start and stop in the same IDLE cycle: no activity. A start pulse during PLAY: no restart, and note_idx keeps advancing.
- mute=1 throughout: audio stays 0, but the busy, note_idx and done timing is identical to the first scenario.
- Async rst asserted mid note3, between clock edges: all outputs go to 0 immediately. A start after release replays from note 0.
